// File: rtl/ad9363_tx_sched.sv
// rtl/ad9363_tx_sched.sv - AD9363 TX burst scheduler with TXNRX guard/tail sequencing
// Two requesters share one TX stream. Grants are round-robin and held for a whole burst.
module ad9363_tx_sched #(
  parameter int GUARD_CYCLES = 16,
  parameter int TAIL_CYCLES  = 8,
  parameter int MAX_BURST    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [11:0] req0_data_i,
  input  logic [11:0] req0_data_q,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_data_i,
  input  logic [11:0] req1_data_q,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        tx_valid,
  output logic [11:0] tx_data_i,
  output logic [11:0] tx_data_q,
  input  logic        tx_ready,
  output logic        ensm_txnrx,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err_overrun
);

  localparam int CMAX = (GUARD_CYCLES > TAIL_CYCLES) ? GUARD_CYCLES : TAIL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, LEAD, STREAM, TAIL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] beats;
  logic          rr_last;
  logic          owner;

  logic any_valid;
  logic pick;
  logic streaming;
  logic sel_valid;
  logic sel_last;
  logic xfer;
  logic at_max;

  // Ties go to whoever was not granted most recently; a lone requester always wins.
  assign any_valid = req0_valid | req1_valid;
  assign pick      = (req0_valid & req1_valid) ? ~rr_last : req1_valid;

  assign streaming = (state == STREAM);
  assign sel_valid = owner ? req1_valid : req0_valid;
  assign sel_last  = owner ? req1_last : req0_last;

  assign tx_valid   = streaming & sel_valid;
  assign tx_data_i  = streaming ? (owner ? req1_data_i : req0_data_i) : 12'd0;
  assign tx_data_q  = streaming ? (owner ? req1_data_q : req0_data_q) : 12'd0;
  assign req0_ready = streaming & ~owner & tx_ready;
  assign req1_ready = streaming & owner & tx_ready;

  assign xfer   = tx_valid & tx_ready;
  assign at_max = (beats == BW'(MAX_BURST - 1));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      beats       <= '0;
      rr_last     <= 1'b1;
      owner       <= 1'b0;
      grant       <= 2'b00;
      ensm_txnrx  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            state      <= LEAD;
            owner      <= pick;
            rr_last    <= pick;
            grant      <= pick ? 2'b10 : 2'b01;
            ensm_txnrx <= 1'b1;
            cnt        <= CW'(GUARD_CYCLES - 1);
          end
        end
        LEAD: begin
          if (cnt == '0) begin
            state <= STREAM;
            beats <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            beats <= beats + 1'b1;
            // Hitting MAX_BURST without last truncates the burst and flags it.
            if (sel_last || at_max) begin
              state       <= TAIL;
              grant       <= 2'b00;
              cnt         <= CW'(TAIL_CYCLES - 1);
              err_overrun <= ~sel_last;
            end
          end
        end
        TAIL: begin
          // TXNRX is still high here, so a new winner skips the guard interval.
          if (any_valid) begin
            state   <= STREAM;
            owner   <= pick;
            rr_last <= pick;
            grant   <= pick ? 2'b10 : 2'b01;
            beats   <= '0;
          end else if (cnt == '0) begin
            state      <= IDLE;
            ensm_txnrx <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9363_tx_sched.sv
// tb/tb_ad9363_tx_sched.sv - directed scenarios with a burst-level round-robin reference
// dut_a uses the default timing; dut_b covers GUARD=1/TAIL=1 and MAX_BURST=8.
module tb_ad9363_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel;
  logic r0v, r1v, r0l, r1l, tx_ready;
  logic [11:0] r0i, r0q, r1i, r1q;

  logic a_r0rdy, a_r1rdy, a_txv, a_ensm, a_busy, a_err;
  logic b_r0rdy, b_r1rdy, b_txv, b_ensm, b_busy, b_err;
  logic [11:0] a_txi, a_txq, b_txi, b_txq;
  logic [1:0] a_grant, b_grant;

  ad9363_tx_sched #(.GUARD_CYCLES(16), .TAIL_CYCLES(8), .MAX_BURST(4096)) dut_a (
    .clk(clk), .rst(rst_a),
    .req0_valid(r0v), .req0_data_i(r0i), .req0_data_q(r0q), .req0_last(r0l), .req0_ready(a_r0rdy),
    .req1_valid(r1v), .req1_data_i(r1i), .req1_data_q(r1q), .req1_last(r1l), .req1_ready(a_r1rdy),
    .tx_valid(a_txv), .tx_data_i(a_txi), .tx_data_q(a_txq), .tx_ready(tx_ready),
    .ensm_txnrx(a_ensm), .grant(a_grant), .busy(a_busy), .err_overrun(a_err));

  ad9363_tx_sched #(.GUARD_CYCLES(1), .TAIL_CYCLES(1), .MAX_BURST(8)) dut_b (
    .clk(clk), .rst(rst_b),
    .req0_valid(r0v), .req0_data_i(r0i), .req0_data_q(r0q), .req0_last(r0l), .req0_ready(b_r0rdy),
    .req1_valid(r1v), .req1_data_i(r1i), .req1_data_q(r1q), .req1_last(r1l), .req1_ready(b_r1rdy),
    .tx_valid(b_txv), .tx_data_i(b_txi), .tx_data_q(b_txq), .tx_ready(tx_ready),
    .ensm_txnrx(b_ensm), .grant(b_grant), .busy(b_busy), .err_overrun(b_err));

  logic o_r0rdy, o_r1rdy, o_txv, o_ensm, o_busy, o_err;
  logic [11:0] o_txi, o_txq;
  logic [1:0] o_grant;
  assign o_r0rdy = sel ? b_r0rdy : a_r0rdy;
  assign o_r1rdy = sel ? b_r1rdy : a_r1rdy;
  assign o_txv   = sel ? b_txv : a_txv;
  assign o_ensm  = sel ? b_ensm : a_ensm;
  assign o_busy  = sel ? b_busy : a_busy;
  assign o_err   = sel ? b_err : a_err;
  assign o_txi   = sel ? b_txi : a_txi;
  assign o_txq   = sel ? b_txq : a_txq;
  assign o_grant = sel ? b_grant : a_grant;

  typedef struct packed {logic [11:0] i; logic [11:0] q; logic last;} smp_t;
  typedef struct packed {logic own; logic [11:0] i; logic [11:0] q;} exp_t;

  smp_t src0[$], src1[$];
  exp_t expq[$];
  int   xfer_cyc[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, vcyc, rise_cyc, fall_cyc, first_tx, rises, errs, err_cyc;
  int   guard, tail, maxb, ready_mode;
  bit   prev_ensm, mdl_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    r0v = (src0.size() > 0);
    r0i = r0v ? src0[0].i : 12'd0;
    r0q = r0v ? src0[0].q : 12'd0;
    r0l = r0v ? src0[0].last : 1'b0;
    r1v = (src1.size() > 0);
    r1i = r1v ? src1[0].i : 12'd0;
    r1q = r1v ? src1[0].q : 12'd0;
    r1l = r1v ? src1[0].last : 1'b0;
  endtask

  // Burst-level reference: every loaded requester holds valid continuously, so the
  // output is whole bursts (cut at maxb) in round-robin order.
  task automatic plan();
    smp_t m0[$], m1[$];
    m0 = src0;
    m1 = src1;
    while (m0.size() > 0 || m1.size() > 0) begin
      bit w;
      int n;
      bit done;
      w = (m0.size() > 0 && m1.size() > 0) ? ~mdl_last : (m1.size() > 0);
      mdl_last = w;
      n = 0;
      done = 1'b0;
      while (!done) begin
        smp_t s;
        if (w && m1.size() == 0) break;
        if (!w && m0.size() == 0) break;
        s = w ? m1.pop_front() : m0.pop_front();
        expq.push_back({w, s.i, s.q});
        n++;
        done = s.last || (n == maxb);
      end
    end
  endtask

  task automatic push_burst(input bit r, input int n, input bit ramp, input bit with_last);
    for (int k = 1; k <= n; k++) begin
      smp_t s;
      s.i = ramp ? 12'(k) : 12'($urandom);
      s.q = ramp ? 12'(-k) : 12'($urandom);
      s.last = with_last && (k == n);
      if (r) src1.push_back(s);
      else src0.push_back(s);
    end
  endtask

  task automatic start();
    plan();
    drive();
    vcyc = cyc;
    first_tx = -1; rise_cyc = -1; fall_cyc = -1; rises = 0; errs = 0; err_cyc = -1;
    xfer_cyc.delete();
  endtask

  task automatic tick();
    exp_t e;
    logic x0, x1;
    @(negedge clk);
    if (o_ensm === 1'b1 && !prev_ensm) begin rises++; rise_cyc = cyc; end
    if (o_ensm === 1'b0 && prev_ensm) fall_cyc = cyc;
    prev_ensm = (o_ensm === 1'b1);
    if (o_err === 1'b1) begin errs++; err_cyc = cyc; end
    if (o_txv === 1'b1) begin
      if (first_tx < 0) first_tx = cyc;
      check("ready_mirror", 32'(o_r0rdy | o_r1rdy), 32'(tx_ready));
    end
    if (o_txv === 1'b1 && tx_ready === 1'b1) begin
      xfer_cyc.push_back(cyc);
      check("xfer_pending", 32'(expq.size() > 0), 32'(1));
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("data_i", 32'(o_txi), 32'(e.i));
        check("data_q", 32'(o_txq), 32'(e.q));
        check("owner_ready", 32'({o_r1rdy, o_r0rdy}), e.own ? 32'(2) : 32'(1));
        check("owner_grant", 32'(o_grant), e.own ? 32'(2) : 32'(1));
      end
    end
    x0 = o_r0rdy & r0v;
    x1 = o_r1rdy & r1v;
    @(posedge clk);
    #1;
    cyc++;
    if (x0 === 1'b1 && src0.size() > 0) void'(src0.pop_front());
    if (x1 === 1'b1 && src1.size() > 0) void'(src1.pop_front());
    case (ready_mode)
      1: tx_ready = ~tx_ready;
      2: tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
    drive();
  endtask

  task automatic run(input int budget, input bit wait_idle);
    int n = 0;
    while ((expq.size() != 0 || (wait_idle && fall_cyc < 0)) && n < budget) begin
      tick();
      n++;
    end
    check("run_budget", 32'(n < budget), 32'(1));
  endtask

  task automatic do_reset(input bit which);
    sel = which;
    rst_a = 1'b1;
    rst_b = 1'b1;
    src0.delete(); src1.delete(); expq.delete();
    ready_mode = 0;
    tx_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    if (which) rst_b = 1'b0;
    else rst_a = 1'b0;
    guard = which ? 1 : 16;
    tail  = which ? 1 : 8;
    maxb  = which ? 8 : 4096;
    mdl_last = 1'b1;
    prev_ensm = 1'b0;
    #1;
    check("rst_ensm", 32'(o_ensm), 32'(0));
    check("rst_grant", 32'(o_grant), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_err", 32'(o_err), 32'(0));
    check("rst_txv", 32'(o_txv), 32'(0));
    check("rst_txdata", 32'({o_txi, o_txq}), 32'(0));
    check("rst_ready", 32'({o_r1rdy, o_r0rdy}), 32'(0));
  endtask

  task automatic check_timing(input string tag);
    check({tag, "_rise"}, 32'(rise_cyc), 32'(vcyc + 1));
    check({tag, "_first_tx"}, 32'(first_tx), 32'(vcyc + 1 + guard));
    check({tag, "_fall"}, 32'(fall_cyc), 32'(xfer_cyc[$] + tail + 1));
    check({tag, "_rises"}, 32'(rises), 32'(1));
    check({tag, "_drained"}, 32'(expq.size()), 32'(0));
  endtask

  initial begin
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; tx_ready = 1'b1; ready_mode = 0;
    drive();

    // Single ramp burst on the default timing.
    do_reset(1'b0);
    push_burst(1'b0, 10, 1'b1, 1'b1);
    start();
    tick();
    check("lead_busy", 32'(o_busy), 32'(1));
    check("lead_grant", 32'(o_grant), 32'(1));
    check("lead_txv", 32'(o_txv), 32'(0));
    run(200, 1'b1);
    check_timing("single");
    check("single_count", 32'(xfer_cyc.size()), 32'(10));
    check("single_noerr", 32'(errs), 32'(0));

    // Tie from IDLE, then hand-offs inside TAIL with no new guard interval.
    do_reset(1'b0);
    push_burst(1'b0, 4, 1'b0, 1'b1);
    push_burst(1'b0, 4, 1'b0, 1'b1);
    push_burst(1'b1, 4, 1'b0, 1'b1);
    start();
    run(300, 1'b1);
    check_timing("tie");
    check("tie_span", 32'(xfer_cyc[$]), 32'(first_tx + 12 - 1 + 2));

    // Alternating backpressure over a 20-sample burst.
    ready_mode = 1;
    push_burst(1'b0, 20, 1'b0, 1'b1);
    start();
    run(300, 1'b1);
    check_timing("bp");
    check("bp_count", 32'(xfer_cyc.size()), 32'(20));

    // Asynchronous reset after three transfers, then a fresh request pays the full LEAD.
    ready_mode = 0;
    tx_ready = 1'b1;
    push_burst(1'b0, 10, 1'b0, 1'b1);
    start();
    for (int n = 0; n < 100 && xfer_cyc.size() < 3; n++) tick();
    check("mid_xfers", 32'(xfer_cyc.size()), 32'(3));
    check("mid_streaming", 32'(o_txv), 32'(1));
    #2;
    rst_a = 1'b1;
    #1;
    check("arst_ensm", 32'(o_ensm), 32'(0));
    check("arst_grant", 32'(o_grant), 32'(0));
    check("arst_ready", 32'({o_r1rdy, o_r0rdy}), 32'(0));
    check("arst_txv", 32'(o_txv), 32'(0));
    @(posedge clk);
    #1;
    src0.delete(); src1.delete(); expq.delete();
    drive();
    rst_a = 1'b0;
    mdl_last = 1'b1;
    prev_ensm = 1'b0;
    ready_mode = 2;
    push_burst(1'b0, 6, 1'b0, 1'b1);
    start();
    run(300, 1'b1);
    check_timing("rerun");

    // Shortest guard and tail.
    do_reset(1'b1);
    ready_mode = 2;
    push_burst(1'b0, 5, 1'b0, 1'b1);
    start();
    run(200, 1'b1);
    check_timing("short");

    // Truncation at MAX_BURST=8: req1 wins again from TAIL and then holds the grant.
    ready_mode = 0;
    tx_ready = 1'b1;
    push_burst(1'b1, 12, 1'b0, 1'b0);
    start();
    run(200, 1'b0);
    repeat (3) tick();
    check("ovr_count", 32'(xfer_cyc.size()), 32'(12));
    check("ovr_first_tx", 32'(first_tx), 32'(vcyc + 1 + guard));
    check("ovr_pulses", 32'(errs), 32'(1));
    if (xfer_cyc.size() >= 9) begin
      check("ovr_err_cycle", 32'(err_cyc), 32'(xfer_cyc[7] + 1));
      check("ovr_resume", 32'(xfer_cyc[8]), 32'(xfer_cyc[7] + 2));
    end
    check("ovr_grant_held", 32'(o_grant), 32'(2));
    check("ovr_busy_held", 32'(o_busy), 32'(1));
    check("ovr_ensm_held", 32'(o_ensm), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
